mips_cpu_muldiv_ctrl: RTL and testbench

Multi-cycle multiply/divide sequencer that owns the HI/LO register pair for the MIPS CPU. It replaces the single-cycle combinational product/quotient/remainder logic. It runs radix-2 iterative MULT, MULTU, DIV and DIVU, services MTHI/MTLO, and raises a stall to the CPU core when an instruction touches HI/LO while an operation is still in flight.

---
 rtl/mips_cpu_muldiv_ctrl.sv | 154 +++++++++++++++
 tb/tb_mips_cpu_muldiv_ctrl.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/mips_cpu_muldiv_ctrl.sv
// Multi-cycle multiply/divide sequencer that owns the HI/LO register pair.
// It runs radix-2 iterative MULT/MULTU (shift-add) and DIV/DIVU (restoring
// shift-subtract) on operand magnitudes, then applies the sign fix in a final
// cycle. It also stalls the core when HI/LO is touched while busy.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting; accepts start, MTHI and MTLO (start has priority)
// RUN   | one iteration step per cycle, ITER cycles in total
// FIX   | sign correction and HI/LO write; busy drops on this edge
module mips_cpu_muldiv_ctrl #(
    parameter int ITER = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic        mthi,
    input  logic        mtlo,
    input  logic [31:0] mt_data,
    input  logic        hilo_read,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        stall
);

    localparam int CW = $clog2(ITER);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

    state_t      r_state;
    logic [CW-1:0] r_cnt;
    logic        r_is_div;
    logic        r_neg_a;
    logic        r_neg_b;
    logic [31:0] r_a_raw;
    logic [31:0] r_b;
    // Multiply: upper/lower product halves. Divide: remainder/quotient.
    logic [31:0] r_hi_acc;
    logic [31:0] r_lo_acc;

    logic        w_signed;
    logic        w_a_neg;
    logic        w_b_neg;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic [32:0] w_mul_sum;
    logic [32:0] w_div_sh;
    logic        w_div_ge;
    logic [31:0] w_div_sub;
    logic [63:0] w_prod;
    logic [63:0] w_prod_fix;
    logic [31:0] w_quo_fix;
    logic [31:0] w_rem_fix;

    // Operand magnitudes; signs only count for MULT and DIV (op[0] == 0).
    assign w_signed = ~op[0];
    assign w_a_neg  = w_signed & op_a[31];
    assign w_b_neg  = w_signed & op_b[31];
    assign w_a_mag  = w_a_neg ? (32'd0 - op_a) : op_a;
    assign w_b_mag  = w_b_neg ? (32'd0 - op_b) : op_b;

    // Shift-add step: carry out of the add is shifted into the upper half.
    assign w_mul_sum = {1'b0, r_hi_acc} + (r_lo_acc[0] ? {1'b0, r_b} : 33'd0);

    // Restoring divide step. The shifted partial remainder needs 33 bits;
    // after a successful subtract the result always fits back in 32.
    assign w_div_sh  = {r_hi_acc, r_lo_acc[31]};
    assign w_div_ge  = (w_div_sh >= {1'b0, r_b});
    assign w_div_sub = w_div_sh[31:0] - r_b;

    assign w_prod     = {r_hi_acc, r_lo_acc};
    assign w_prod_fix = (r_neg_a ^ r_neg_b) ? (64'd0 - w_prod) : w_prod;
    assign w_quo_fix  = (r_neg_a ^ r_neg_b) ? (32'd0 - r_lo_acc) : r_lo_acc;
    assign w_rem_fix  = r_neg_a ? (32'd0 - r_hi_acc) : r_hi_acc;

    // Core must hold the instruction whenever it touches HI/LO mid-operation.
    assign stall = busy & (start | mthi | mtlo | hilo_read);

    // Sequencer: accept, iterate, correct signs and commit HI/LO.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_is_div <= 1'b0;
            r_neg_a  <= 1'b0;
            r_neg_b  <= 1'b0;
            r_a_raw  <= '0;
            r_b      <= '0;
            r_hi_acc <= '0;
            r_lo_acc <= '0;
            hi       <= '0;
            lo       <= '0;
            busy     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_is_div <= op[1];
                        r_neg_a  <= w_a_neg;
                        r_neg_b  <= w_b_neg;
                        r_a_raw  <= op_a;
                        r_b      <= w_b_mag;
                        r_hi_acc <= '0;
                        r_lo_acc <= w_a_mag;
                        r_cnt    <= '0;
                        busy     <= 1'b1;
                        r_state  <= S_RUN;
                    end else begin
                        if (mthi) hi <= mt_data;
                        if (mtlo) lo <= mt_data;
                    end
                end
                S_RUN: begin
                    if (r_is_div) begin
                        r_hi_acc <= w_div_ge ? w_div_sub : w_div_sh[31:0];
                        r_lo_acc <= {r_lo_acc[30:0], w_div_ge};
                    end else begin
                        r_hi_acc <= w_mul_sum[32:1];
                        r_lo_acc <= {w_mul_sum[0], r_lo_acc[31:1]};
                    end
                    if (r_cnt == CW'(ITER - 1)) begin
                        r_state <= S_FIX;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_FIX: begin
                    if (!r_is_div) begin
                        hi <= w_prod_fix[63:32];
                        lo <= w_prod_fix[31:0];
                    end else if (r_b == 32'd0) begin
                        // Divide by zero: all-ones quotient, raw dividend as remainder.
                        hi <= r_a_raw;
                        lo <= 32'hFFFF_FFFF;
                    end else begin
                        hi <= w_rem_fix;
                        lo <= w_quo_fix;
                    end
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mips_cpu_muldiv_ctrl.sv
// Directed bench for the multiply/divide sequencer: latency, results, stall
// behaviour, ignored requests while busy, MTHI/MTLO and mid-operation reset.
module tb_mips_cpu_muldiv_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        mthi;
    logic        mtlo;
    logic [31:0] mt_data;
    logic        hilo_read;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        stall;

    int errors = 0;
    int checks = 0;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    mips_cpu_muldiv_ctrl #(.ITER(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .op_a      (op_a),
        .op_b      (op_b),
        .mthi      (mthi),
        .mtlo      (mtlo),
        .mt_data   (mt_data),
        .hilo_read (hilo_read),
        .hi        (hi),
        .lo        (lo),
        .busy      (busy),
        .stall     (stall)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one operation from IDLE; inputs change #1 after a rising edge.
    // rd holds hilo_read through the operation; inj pulses start+mthi mid-run.
    task automatic run_op(input string tag, input logic [1:0] o,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                          input bit rd, input bit inj);
        logic [31:0] old_hi;
        logic [31:0] old_lo;
        int n;
        old_hi = hi;
        old_lo = lo;
        op = o; op_a = a; op_b = b; start = 1'b1; hilo_read = rd;
        #1;
        chk({tag, " stall@accept"}, {31'd0, stall}, 32'd0);
        @(posedge clk); #1;
        start = 1'b0;
        op_a = ~a; op_b = ~b;
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            if (rd) chk({tag, " stall busy"}, {31'd0, stall}, 32'd1);
            chk({tag, " hi hold"}, hi, old_hi);
            chk({tag, " lo hold"}, lo, old_lo);
            if (inj && n == 5) begin
                start = 1'b1; op = OP_MULTU; op_a = 32'd1; op_b = 32'd1;
                mthi = 1'b1; mt_data = 32'h1234;
                #1;
                chk({tag, " stall inject"}, {31'd0, stall}, 32'd1);
            end
            @(posedge clk); #1;
            start = 1'b0; mthi = 1'b0;
        end
        chk({tag, " busy cycles"}, n, 32'd33);
        if (rd) chk({tag, " stall idle"}, {31'd0, stall}, 32'd0);
        hilo_read = 1'b0;
        chk({tag, " hi"}, hi, exp_hi);
        chk({tag, " lo"}, lo, exp_lo);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; op = 2'b00; op_a = '0; op_b = '0;
        mthi = 1'b0; mtlo = 1'b0; mt_data = '0; hilo_read = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        chk("reset hi", hi, 32'd0);
        chk("reset lo", lo, 32'd0);
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset stall", {31'd0, stall}, 32'd0);

        run_op("multu max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 1'b0);
        run_op("mult -3*7 rd", OP_MULT, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b1, 1'b0);
        run_op("div -7/2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 1'b0);
        run_op("divu 100/7", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 1'b0);
        run_op("div min/-1", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0, 1'b0);
        run_op("divu 5/0", OP_DIVU, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b0, 1'b0);
        run_op("div -5/0", OP_DIV, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b0, 1'b0);
        run_op("div 100/-7 inj", OP_DIV, 32'd100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFF2, 1'b0, 1'b1);

        // MTHI in IDLE writes HI only.
        mthi = 1'b1; mt_data = 32'h1234;
        @(posedge clk); #1;
        mthi = 1'b0;
        chk("mthi hi", hi, 32'h1234);
        chk("mthi lo", lo, 32'hFFFF_FFF2);

        // MTLO in IDLE writes LO only.
        mtlo = 1'b1; mt_data = 32'h0000_ABCD;
        @(posedge clk); #1;
        mtlo = 1'b0;
        chk("mtlo hi", hi, 32'h1234);
        chk("mtlo lo", lo, 32'h0000_ABCD);

        // start alongside MTHI/MTLO: the moves are dropped.
        run_op("start beats mt", OP_MULTU, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0, 1'b0);

        // Reset at RUN cycle 10 aborts with HI/LO cleared.
        op = OP_MULT; op_a = 32'd5; op_b = 32'd5; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("abort busy", {31'd0, busy}, 32'd0);
        chk("abort hi", hi, 32'd0);
        chk("abort lo", lo, 32'd0);

        run_op("multu 6*7", OP_MULTU, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Drives mthi/mtlo during the "start beats mt" accept cycle.
    initial begin
        wait (checks > 0);
        forever begin
            @(negedge clk);
            if (start === 1'b1 && op_a === 32'd3 && op_b === 32'd4 && busy === 1'b0) begin
                mthi = 1'b1; mtlo = 1'b1; mt_data = 32'hDEAD_BEEF;
                @(posedge clk); #1;
                mthi = 1'b0; mtlo = 1'b0;
            end
        end
    end

endmodule
